// File: rtl/mc_sequencer.sv
// mc_sequencer: drives the memory controller through store, transfer/process
// rounds and drain. Optional watchdog: define SEQ_WATCHDOG_EN.

module mc_sequencer #(
    parameter int NUM_PU      = 4,
    parameter int WDOG_CYCLES = 255
) (
    input  logic              mc_clk,
    input  logic              mc_reset,
    input  logic              seq_start,
    input  logic [5:0]        seq_length,
    input  logic              seq_abort,
    input  logic              mc_done,
    input  logic              mc_data_done,
    input  logic [NUM_PU-1:0] pu_done,
    output logic [2:0]        mc_data_contition,
    output logic [5:0]        mc_data_length,
    output logic [NUM_PU-1:0] pu_load,
    output logic              pu_start,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_error
);

    if (NUM_PU < 1 || NUM_PU > 8 ||
        WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_param_chk
        $error("mc_sequencer: parameter out of range");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_STORE,
        S_XBLANK,
        S_XFER,
        S_PSTART,
        S_PROC,
        S_FIN,
        S_DRAIN0,
        S_DRAIN1,
        S_DRAIN2
    } state_t;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_STORE = 3'b100;
    localparam logic [2:0] CMD_XFER  = 3'b010;
    localparam logic [2:0] CMD_PROC  = 3'b001;
    localparam logic [2:0] LAST_SLOT = 3'(NUM_PU - 1);

    state_t            state;
    state_t            state_nxt;
    logic [6:0]        word_cnt;
    logic [6:0]        word_nxt;
    logic [2:0]        slot;
    logic [2:0]        slot_nxt;
    logic [NUM_PU-1:0] ld_mask;
    logic [NUM_PU-1:0] ld_mask_nxt;
    logic              dd_seen;
    logic              dd_nxt;
    logic [5:0]        len_nxt;
    logic [NUM_PU-1:0] load_nxt;
    logic [2:0]        cmd_nxt;
    logic [NUM_PU-1:0] slot_sel;
    logic [6:0]        len_p1;
    logic [6:0]        word_inc;
    logic              all_done;
    logic              last_word;
    logic              abort_ok;
    logic              wdog_trip;

    assign slot_sel  = NUM_PU'(1) << slot;
    assign len_p1    = {1'b0, mc_data_length} + 7'd1;
    assign word_inc  = word_cnt + 7'd1;
    assign all_done  = ((pu_done & ld_mask) == ld_mask);
    assign last_word = (word_cnt == len_p1) || dd_seen;
    assign abort_ok  = seq_abort &&
        !(state inside {S_IDLE, S_DRAIN0, S_DRAIN1, S_DRAIN2});

    // next state, round bookkeeping and load strobe
    always_comb begin
        state_nxt   = state;
        word_nxt    = word_cnt;
        slot_nxt    = slot;
        ld_mask_nxt = ld_mask;
        dd_nxt      = dd_seen;
        len_nxt     = mc_data_length;
        load_nxt    = '0;
        unique case (state)
            S_IDLE: begin
                if (seq_start) begin
                    len_nxt     = seq_length;
                    word_nxt    = '0;
                    slot_nxt    = '0;
                    ld_mask_nxt = '0;
                    dd_nxt      = 1'b0;
                    state_nxt   = S_STORE;
                end
            end
            S_STORE: begin
                if (mc_done) state_nxt = S_XBLANK;
            end
            S_XBLANK: state_nxt = S_XFER;
            S_XFER: begin
                if (mc_done) begin
                    load_nxt    = slot_sel;
                    ld_mask_nxt = ld_mask | slot_sel;
                    slot_nxt    = slot + 3'd1;
                    word_nxt    = word_inc;
                    if (slot == LAST_SLOT || word_inc == len_p1)
                        state_nxt = S_PSTART;
                end
                if (mc_data_done) begin
                    dd_nxt    = 1'b1;
                    state_nxt = S_PSTART;
                end
            end
            S_PSTART: state_nxt = S_PROC;
            S_PROC: begin
                if (all_done) begin
                    if (last_word) begin
                        state_nxt = S_FIN;
                    end else begin
                        slot_nxt    = '0;
                        ld_mask_nxt = '0;
                        state_nxt   = S_XBLANK;
                    end
                end
            end
            S_FIN:    state_nxt = S_IDLE;
            S_DRAIN0: state_nxt = S_DRAIN1;
            S_DRAIN1: state_nxt = S_DRAIN2;
            S_DRAIN2: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (wdog_trip || abort_ok) begin
            state_nxt = S_DRAIN0;
            load_nxt  = '0;
        end
    end

    // command code seen by the controller while in the next state
    always_comb begin
        cmd_nxt = CMD_IDLE;
        unique case (1'b1)
            state_nxt == S_STORE:
                cmd_nxt = CMD_STORE;
            state_nxt inside {S_XBLANK, S_XFER, S_DRAIN0}:
                cmd_nxt = CMD_XFER;
            state_nxt inside {S_PSTART, S_PROC, S_DRAIN1}:
                cmd_nxt = CMD_PROC;
            default:
                cmd_nxt = CMD_IDLE;
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge mc_clk or posedge mc_reset) begin
        if (mc_reset) begin
            state             <= S_IDLE;
            word_cnt          <= '0;
            slot              <= '0;
            ld_mask           <= '0;
            dd_seen           <= 1'b0;
            mc_data_length    <= '0;
            mc_data_contition <= CMD_IDLE;
            pu_load           <= '0;
            pu_start          <= 1'b0;
            seq_busy          <= 1'b0;
            seq_done          <= 1'b0;
        end else begin
            state             <= state_nxt;
            word_cnt          <= word_nxt;
            slot              <= slot_nxt;
            ld_mask           <= ld_mask_nxt;
            dd_seen           <= dd_nxt;
            mc_data_length    <= len_nxt;
            mc_data_contition <= cmd_nxt;
            pu_load           <= load_nxt;
            pu_start          <= (state_nxt == S_PSTART);
            seq_busy          <= (state_nxt != S_IDLE);
            seq_done          <= (state_nxt == S_FIN);
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam logic [7:0] WDOG_LIM = 8'(WDOG_CYCLES);

    logic [7:0]        wdog_cnt;
    logic [NUM_PU-1:0] pu_done_q;
    logic              error_q;
    logic              wdog_watch;
    logic              wdog_kick;

    assign wdog_watch = state inside {S_STORE, S_XFER, S_PROC};
    assign wdog_kick  = mc_done || (pu_done != pu_done_q);
    assign wdog_trip  = wdog_watch && !wdog_kick &&
                        (wdog_cnt + 8'd1 == WDOG_LIM);
    assign seq_error  = error_q;

    // stall counter restarts on state change or any handshake activity
    always_ff @(posedge mc_clk or posedge mc_reset) begin
        if (mc_reset) begin
            wdog_cnt  <= '0;
            pu_done_q <= '0;
            error_q   <= 1'b0;
        end else begin
            pu_done_q <= pu_done;
            if (state_nxt != state || wdog_kick)
                wdog_cnt <= '0;
            else
                wdog_cnt <= wdog_cnt + 8'd1;
            if (state == S_IDLE && seq_start)
                error_q <= 1'b0;
            else if (wdog_trip)
                error_q <= 1'b1;
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: scoreboard bench for mc_sequencer with behavioural
// memory-controller and processing-unit models.

module tb_mc_sequencer;

    localparam int NP = 4;

    logic          mc_clk = 1'b0;
    logic          mc_reset = 1'b1;
    logic          seq_start = 1'b0;
    logic [5:0]    seq_length = '0;
    logic          seq_abort = 1'b0;
    logic          mc_done = 1'b0;
    logic          mc_data_done = 1'b0;
    logic [NP-1:0] pu_done = '0;
    logic [2:0]    mc_data_contition;
    logic [5:0]    mc_data_length;
    logic [NP-1:0] pu_load;
    logic          pu_start;
    logic          seq_busy;
    logic          seq_done;
    logic          seq_error;

    int            n_vec = 0;
    int            n_mis = 0;
    int            n_done = 0;
    int            n_start = 0;
    int            dd_word = -1;
    bit            pu_hold = 1'b0;
    logic [2:0]    mdl_code = 3'b000;
    logic [2:0]    cmd_q[$];
    logic [NP-1:0] load_q[$];

    mc_sequencer #(
        .NUM_PU      (NP),
        .WDOG_CYCLES (16)
    ) dut (
        .mc_clk            (mc_clk),
        .mc_reset          (mc_reset),
        .seq_start         (seq_start),
        .seq_length        (seq_length),
        .seq_abort         (seq_abort),
        .mc_done           (mc_done),
        .mc_data_done      (mc_data_done),
        .pu_done           (pu_done),
        .mc_data_contition (mc_data_contition),
        .mc_data_length    (mc_data_length),
        .pu_load           (pu_load),
        .pu_start          (pu_start),
        .seq_busy          (seq_busy),
        .seq_done          (seq_done),
        .seq_error         (seq_error)
    );

    always #5 mc_clk = ~mc_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // memory controller: store done after 2 cycles, one word per cycle
    // in transfer mode after a blank first cycle
    initial begin : mc_model
        int run;
        int wcnt;
        logic [2:0] prev;
        run = 0;
        wcnt = 0;
        prev = 3'b000;
        forever begin
            @(negedge mc_clk);
            if (mc_reset) begin
                mc_done = 1'b0;
                mc_data_done = 1'b0;
                run = 0;
                wcnt = 0;
                prev = 3'b000;
            end else begin
                case (mc_data_contition)
                    3'b100: begin
                        if (prev != 3'b100) begin
                            run = 0;
                            wcnt = 0;
                        end
                        run++;
                        mc_done = (run == 2);
                        mc_data_done = 1'b0;
                    end
                    3'b010: begin
                        if (prev != 3'b010) run = 0;
                        else run++;
                        mc_done = (run >= 1);
                        if (mc_done && wcnt == dd_word)
                            mc_data_done = 1'b1;
                        if (mc_done) wcnt++;
                    end
                    default: begin
                        mc_done = 1'b0;
                        if (mc_data_contition == 3'b000)
                            mc_data_done = 1'b0;
                    end
                endcase
                prev = mc_data_contition;
            end
            mdl_code = prev;
        end
    end

    // processing units: finish one loaded unit per cycle after a delay
    initial begin : pu_model
        logic [NP-1:0] loaded;
        int pd;
        bit active;
        bit chk_next;
        bit found;
        loaded = '0;
        pd = 0;
        active = 1'b0;
        chk_next = 1'b0;
        forever begin
            @(negedge mc_clk);
            if (chk_next) begin
                chk("pd_to_cmd", 32'(mc_data_contition == 3'b001), 32'd0);
                chk_next = 1'b0;
            end
            if (mc_reset || !seq_busy) begin
                loaded = '0;
                active = 1'b0;
                if (mc_reset) pu_done = '0;
            end else begin
                loaded |= pu_load;
                if (pu_start) begin
                    pu_done = '0;
                    active = 1'b1;
                    pd = 0;
                end else if (active && !pu_hold) begin
                    pd++;
                    if (pd >= 2) begin
                        found = 1'b0;
                        for (int i = 0; i < NP; i++) begin
                            if (!found && loaded[i] && !pu_done[i]) begin
                                pu_done[i] = 1'b1;
                                found = 1'b1;
                            end
                        end
                        if ((pu_done & loaded) == loaded) begin
                            active = 1'b0;
                            loaded = '0;
                            chk_next = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // scoreboard: pop expected command changes and load strobes
    initial begin : monitor
        logic [2:0] prev;
        prev = 3'b000;
        forever begin
            @(negedge mc_clk);
            if (mc_reset) begin
                prev = 3'b000;
            end else begin
                if (mc_data_contition != prev) begin
                    if (cmd_q.size() == 0)
                        chk("cmd_unexpected", 32'(mc_data_contition),
                            32'(prev));
                    else
                        chk("cmd_seq", 32'(mc_data_contition),
                            32'(cmd_q.pop_front()));
                    prev = mc_data_contition;
                end
                if (pu_load != '0) begin
                    if (load_q.size() == 0)
                        chk("load_unexpected", 32'(pu_load), 32'd0);
                    else
                        chk("load_seq", 32'(pu_load),
                            32'(load_q.pop_front()));
                end
                if (seq_done) n_done++;
                if (pu_start) n_start++;
            end
        end
    end

    task automatic push_job(input int len, input int dd, output int rounds);
        int rem;
        int n;
        rem = (dd >= 0 && dd <= len) ? dd + 1 : len + 1;
        rounds = 0;
        cmd_q.push_back(3'b100);
        while (rem > 0) begin
            n = (rem < NP) ? rem : NP;
            cmd_q.push_back(3'b010);
            cmd_q.push_back(3'b001);
            for (int i = 0; i < n; i++)
                load_q.push_back(NP'(1) << i);
            rem -= n;
            rounds++;
        end
        cmd_q.push_back(3'b000);
    endtask

    task automatic start_job(input int len);
        @(negedge mc_clk);
        seq_length = 6'(len);
        seq_start = 1'b1;
        @(negedge mc_clk);
        seq_start = 1'b0;
        chk("start_cmd", 32'(mc_data_contition), 32'h4);
        chk("start_busy", 32'(seq_busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (seq_busy && c < 3000) begin
            @(negedge mc_clk);
            c++;
        end
        chk(tag, 32'(seq_busy), 32'd0);
        @(negedge mc_clk);
    endtask

    task automatic end_job(input int exp_done, input int exp_start);
        chk("cmd_left", cmd_q.size(), 32'd0);
        chk("load_left", load_q.size(), 32'd0);
        chk("done_cnt", n_done, exp_done);
        chk("start_cnt", n_start, exp_start);
        cmd_q.delete();
        load_q.delete();
        n_done = 0;
        n_start = 0;
    endtask

    task automatic run_job(input int len, input int dd, input bit poke);
        int r;
        dd_word = dd;
        push_job(len, dd, r);
        start_job(len);
        if (poke) begin
            repeat (2) @(negedge mc_clk);
            seq_start = 1'b1;
            seq_length = 6'd2;
            @(negedge mc_clk);
            seq_start = 1'b0;
            chk("len_hold", 32'(mc_data_length), 32'(len));
        end
        wait_idle("job_timeout");
        chk("idle_cmd", 32'(mc_data_contition), 32'd0);
        end_job(1, r);
    endtask

    initial begin : main
        int c;
        for (int i = 0; i < 6; i++) begin
            @(negedge mc_clk);
            seq_start = i[0];
            seq_abort = ~i[0];
            seq_length = 6'(i * 7);
        end
        chk("rst_cmd", 32'(mc_data_contition), 32'd0);
        chk("rst_len", 32'(mc_data_length), 32'd0);
        chk("rst_load", 32'(pu_load), 32'd0);
        chk("rst_start", 32'(pu_start), 32'd0);
        chk("rst_busy", 32'(seq_busy), 32'd0);
        chk("rst_done", 32'(seq_done), 32'd0);
        chk("rst_err", 32'(seq_error), 32'd0);
        @(negedge mc_clk);
        seq_start = 1'b0;
        seq_abort = 1'b0;
        mc_reset = 1'b0;
        @(negedge mc_clk);

        run_job(3, -1, 1'b0);
        run_job(9, -1, 1'b1);

        dd_word = -1;
        cmd_q.push_back(3'b100);
        cmd_q.push_back(3'b010);
        cmd_q.push_back(3'b001);
        cmd_q.push_back(3'b000);
        load_q.push_back(4'b0001);
        load_q.push_back(4'b0010);
        start_job(9);
        c = 0;
        while (pu_load != 4'b0010 && c < 200) begin
            @(negedge mc_clk);
            c++;
        end
        chk("abort_reach", 32'(pu_load), 32'h2);
        seq_abort = 1'b1;
        @(negedge mc_clk);
        seq_abort = 1'b0;
        chk("abort_c0", 32'(mc_data_contition), 32'h2);
        chk("abort_noload", 32'(pu_load), 32'd0);
        @(negedge mc_clk);
        chk("abort_c1", 32'(mc_data_contition), 32'h1);
        @(negedge mc_clk);
        chk("abort_c2", 32'(mc_data_contition), 32'h0);
        chk("abort_nodone", 32'(seq_done), 32'd0);
        wait_idle("abort_timeout");
        chk("mc_idle", 32'(mdl_code), 32'd0);
        end_job(0, 0);

        run_job(40, 1, 1'b0);
        run_job(0, -1, 1'b0);
        run_job(63, -1, 1'b0);

`ifdef SEQ_WATCHDOG_EN
        pu_hold = 1'b1;
        dd_word = -1;
        cmd_q.push_back(3'b100);
        cmd_q.push_back(3'b010);
        cmd_q.push_back(3'b001);
        cmd_q.push_back(3'b010);
        cmd_q.push_back(3'b001);
        cmd_q.push_back(3'b000);
        load_q.push_back(4'b0001);
        start_job(0);
        wait_idle("wdog_timeout");
        chk("wdog_err", 32'(seq_error), 32'd1);
        end_job(0, 1);
        pu_hold = 1'b0;
        run_job(0, -1, 1'b0);
        chk("wdog_clr", 32'(seq_error), 32'd0);
`endif

        dd_word = -1;
        push_job(20, -1, c);
        start_job(20);
        c = 0;
        while (pu_load == '0 && c < 200) begin
            @(negedge mc_clk);
            c++;
        end
        chk("mid_reach", 32'(pu_load != '0), 32'd1);
        #2 mc_reset = 1'b1;
        #1;
        chk("mid_rst_cmd", 32'(mc_data_contition), 32'd0);
        chk("mid_rst_busy", 32'(seq_busy), 32'd0);
        chk("mid_rst_load", 32'(pu_load), 32'd0);
        repeat (2) @(negedge mc_clk);
        mc_reset = 1'b0;
        cmd_q.delete();
        load_q.delete();
        n_done = 0;
        n_start = 0;
        repeat (2) @(negedge mc_clk);
        chk("post_rst_idle", 32'(seq_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Core-control sequencer that drives the memory controller through a complete job: store, then repeated transfer/process rounds, then return to idle. It sits between the host-side start interface and the memory controller. It issues the 3-bit `mc_data_contition` command codes and watches `mc_done`/`mc_data_done`. It also distributes operand pairs to NUM_PU processing units by slot and gates their start/done handshake.

## Interface
- NUM_PU, 4: number of processing units fed per round (1..8).
- WDOG_CYCLES, 255: watchdog limit in cycles (used only with SEQ_WATCHDOG_EN).
- mc_clk  in  1  clock, rising edge.
- mc_reset  in  1  reset; asynchronous, active-high.
- seq_start  in  1  one-cycle job request; honoured only in S_IDLE.
- seq_length  in  6  last operand index of the job; sampled with seq_start.
- seq_abort  in  1  level; forces drain from any non-idle state.
- mc_done  in  1  memory-controller done / word-valid strobe.
- mc_data_done  in  1  memory controller reached end of memory.
- pu_done  in  NUM_PU  per-unit completion, level.
- mc_data_contition  out  3  command code to the memory controller.
- mc_data_length  out  6  latched seq_length.
- pu_load  out  NUM_PU  one-hot; the addressed unit captures mc_data_out_opa/opb.
- pu_start  out  1  one-cycle pulse that starts all units.
- seq_busy  out  1  high in every state except S_IDLE.
- seq_done  out  1  one-cycle pulse on normal completion.
- seq_error  out  1  sticky watchdog flag; cleared by the next seq_start (SEQ_WATCHDOG_EN only).

## Operation
- Command codes: 000 finish/idle, 100 begin store, 010 halt-store / next-transfer, 001 enter processing.
- S_IDLE: drive 000. On seq_start, latch seq_length into mc_data_length, clear word_cnt (7 bits) and slot (3 bits), then go to S_STORE.
- S_STORE: drive 100. On mc_done=1, go to S_XBLANK.
- S_XBLANK: drive 010 for exactly one cycle and ignore mc_done. Then go to S_XFER.
- S_XFER: drive 010. Each cycle mc_done=1:
  - pu_load[slot] pulses on the next cycle.
  - slot increments and word_cnt increments.
  - When slot reaches NUM_PU, or word_cnt reaches seq_length+1, or mc_data_done=1, go to S_PSTART.
- S_PSTART: drive 001 and pulse pu_start. Go to S_PROC.
- S_PROC: drive 001. Wait until every pu_done bit for slots loaded this round is 1. Unloaded units are masked.
  - If word_cnt == seq_length+1 or mc_data_done has been seen: go to S_FIN.
  - Otherwise: clear slot and go to S_XBLANK.
- S_FIN: drive 000 for one cycle, pulse seq_done, go to S_IDLE.
- S_DRAIN0, S_DRAIN1, S_DRAIN2: drive 010, then 001, then 000, one cycle each, then go to S_IDLE. No seq_done pulse.
  - Entered from any non-idle state on seq_abort, or on watchdog expiry.
  - This sequence returns the memory controller to idle from any of its states.
- seq_start outside S_IDLE is ignored.
- seq_abort has priority over all other transitions.
- word_cnt is 7 bits so seq_length=63 (64 words) never wraps.

## Timing
- Reset values: mc_data_contition=000, mc_data_length=0, pu_load=0, pu_start=0, seq_busy=0, seq_done=0, seq_error=0, state=S_IDLE.
- All outputs are registered.
- seq_start to first 100 on mc_data_contition: 1 cycle.
- mc_done to pu_load pulse: 1 cycle.
- Last pu_done to next command (000 or 010): 1 cycle.
- Abort to 000: 3 cycles.
- Simultaneous mc_done and seq_abort: abort wins and pu_load is suppressed.
- Asynchronous reset mid-job returns to S_IDLE immediately. The memory controller shares mc_reset, so both sides reset together.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - An 8-bit counter clears on each state change and on each mc_done or pu_done edge.
  - In S_STORE, S_XFER and S_PROC, reaching WDOG_CYCLES sets seq_error and enters S_DRAIN0.
- SEQ_WATCHDOG_EN not defined:
  - No counter.
  - seq_error is tied to 0.
  - The sequencer waits indefinitely.

## Test plan
- Reset held with stimulus toggling -> all outputs at reset values; release, then seq_start, seq_length=3 -> next cycle mc_data_contition=100, seq_busy=1.
- seq_length=3, NUM_PU=4, model returns 4 mc_done strobes -> pu_load sequence 0001, 0010, 0100, 1000; one pu_start; pu_done=1111 -> 000, seq_done pulse, S_IDLE.
- seq_length=9, NUM_PU=4 -> three rounds loading 4, 4, 2 units; third round waits only on pu_done[1:0]; codes 010/001 alternate; final 000.
- seq_abort asserted mid-S_XFER -> codes 010, 001, 000 on consecutive cycles; no seq_done; memory-controller model ends idle.
- mc_data_done=1 on the 2nd word with seq_length=40 -> round closes after 2 loads, then S_FIN after pu_done.
- With SEQ_WATCHDOG_EN and WDOG_CYCLES=16, pu_done held 0 -> after 16 cycles in S_PROC seq_error=1 and drain to idle; next seq_start clears seq_error.
